disp_scan_mux: RTL and testbench
================================

Name: disp_scan_mux

Overview:
Time-multiplexed scanner for the 4-digit common-anode seven-segment display. It sits directly upstream of the seven-segment decoder.
- Holds a 16-bit packed-BCD value.
- Each refresh slot, it selects one nibble and drives it to the decoder on digit_out.
- It drives the matching active-low anode on seg_an.
- Value updates are double-buffered and committed only at frame boundaries, so the display never tears.

Parameters:
DIGIT_TICKS, 100000, clk cycles per digit slot (1 kHz per digit at 100 MHz); must be >= 4.
GUARD_TICKS, 16, cycles at start of each slot with all anodes off (anti-ghosting); must be < DIGIT_TICKS.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
value_in  input  16  packed BCD: [15:12]=digit3 (leftmost) ... [3:0]=digit0 (rightmost).
load  input  1  one-cycle strobe; captures value_in into pending register.
digit_en  input  4  per-digit enable; bit i=0 forces digit i dark.
lz_blank  input  1  1 = suppress leading zeros on digits 3..1.
digit_out  output  4  nibble to decoder; 4'hF = blank code (decoder default case blanks it).
seg_an  output  4  active-low anodes; bit i low lights digit i.
digit_idx  output  2  index of digit currently owning the slot.
frame_start  output  1  one-cycle pulse when shadow register commits (slot index wraps to 0).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. All state is cleared asynchronously on rst_n low.
- Reset values:
  - prescaler=0, digit_idx=3, pending=16'h0000, shadow=16'h0000.
  - seg_an=4'b1111, digit_out=4'hF, frame_start=0.
- Prescaler: counts 0..DIGIT_TICKS-1. tick is asserted when prescaler==DIGIT_TICKS-1; on tick the prescaler wraps to 0.
- On tick:
  - digit_idx <= digit_idx+1 mod 4.
  - If the new index is 0, shadow <= next pending and frame_start <= 1 for exactly one cycle.
  - Because digit_idx resets to 3, the first tick after reset starts a frame.
- load:
  - pending <= value_in on any cycle with load=1.
  - If load coincides with the committing tick, value_in bypasses pending straight into shadow (new value wins).
  - Multiple loads within one frame: the last one wins.
- digit_out is registered and updates on the tick edge to shadow nibble [4*idx+3:4*idx] of the new index, or 4'hF if that digit is blanked.
- seg_an is registered:
  - 4'b1111 while prescaler < GUARD_TICKS.
  - Otherwise ~(1<<digit_idx) if the digit is not blanked, else 4'b1111.
- A digit i is blanked when either holds:
  - digit_en[i]==0.
  - lz_blank==1, i>=1, and shadow nibbles i..3 are all 4'h0.
- Digit 0 is never blanked by lz_blank, so value 0 shows a single "0".
- Non-BCD nibbles (A..E) are passed through unmodified; the decoder blanks them. 4'hF in shadow is indistinguishable from blank, which is acceptable.
- digit_en and lz_blank are sampled each cycle. A change is visible from the next cycle's registered outputs; no frame alignment.
- Reset asserted mid-slot or mid-frame: outputs go to reset values immediately (asynchronously). A pending load is lost.
- Exactly one anode bit is ever low at a time; seg_an never has two zeros.
- Latency: load to visible is at most one full frame (4*DIGIT_TICKS) plus GUARD_TICKS plus 1 cycle.

Decomposition:
- Shared package disp_pkg holds:
  - BLANK_CODE=4'hF
  - AN_OFF=4'b1111
  - NUM_DIGITS=4
  - the slot-index width (2)
- One sub-module: refresh_tick, which contains the prescaler, a DIGIT_TICKS parameter, the tick output, and an in_guard output (prescaler<GUARD_TICKS). The rest is flat.

Test Plan:
All scenarios use DIGIT_TICKS=8 and GUARD_TICKS=2.
1. Reset: hold rst_n=0 for 5 cycles -> seg_an=1111, digit_out=F, frame_start=0. Release -> first frame_start pulse on cycle 8, digit_idx=0.
2. Scan: load 16'h1234 before first tick -> slot0 shows digit_out=4 with seg_an=1110 from prescaler 2..7; then 3/1101, 2/1011, 1/0111; sequence repeats; frame_start every 32 cycles.
3. Leading zeros: lz_blank=1, value 16'h0070 -> digits 3,2 give seg_an=1111 and digit_out=F; digit1=7/1101; digit0=0/1110. Value 16'h0000 -> only digit0 lit, showing 0.
4. Mid-frame load: load 16'h5678 during slot 1 -> current frame still shows old value; new value appears from the next frame_start.
5. Coincident load: load 16'h9999 on the exact committing tick cycle -> that same frame shows 9 on all digits.
6. Enable mask and reset: digit_en=0101 -> digits 1 and 3 dark (1111/F). Assert rst_n low during slot 2 -> seg_an=1111 within the same cycle, and shadow is 0 after release.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared constants and helpers for the seven-segment scan multiplexer.
package disp_pkg;

    localparam logic [3:0]  BLANK_CODE = 4'hF;
    localparam logic [3:0]  AN_OFF     = 4'b1111;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned IDX_W      = 2;

    typedef logic [IDX_W-1:0] idx_t;

    // Bit i (i >= 1) is set when nibbles i..3 of value are all zero, i.e. digit i
    // is a leading zero. Digit 0 is never flagged so a zero value still shows "0".
    function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [15:0] value);
        logic [NUM_DIGITS-1:0] m;
        logic                  zero_above;
        m          = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (value[4*i +: 4] == 4'h0);
            m[i]       = zero_above;
        end
        return m;
    endfunction

endpackage

// File: rtl/refresh_tick.sv
// Slot prescaler: counts 0..DIGIT_TICKS-1 and flags the last cycle of each slot.
module refresh_tick #(
    parameter int unsigned DIGIT_TICKS = 100000,
    parameter int unsigned GUARD_TICKS = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o,
    output logic in_guard_o
);

    localparam int unsigned CntW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
    localparam logic [CntW-1:0] CntMax   = CntW'(DIGIT_TICKS - 1);
    localparam logic [CntW-1:0] GuardVal = CntW'(GUARD_TICKS);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count and tick; in_guard looks at the count the outputs will show after
    // this edge, so the registered anodes line up exactly with the guard window.
    always_comb begin
        tick_o     = (cnt_q == CntMax);
        cnt_d      = tick_o ? '0 : cnt_q + 1'b1;
        in_guard_o = (cnt_d < GuardVal);
    end

    // Prescaler register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/disp_scan_mux.sv
// Time-multiplexed 4-digit common-anode display scanner with frame-aligned,
// double-buffered value updates, leading-zero suppression and anti-ghost guard.
module disp_scan_mux
    import disp_pkg::*;
#(
    parameter int unsigned DIGIT_TICKS = 100000,
    parameter int unsigned GUARD_TICKS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value_in,
    input  logic        load,
    input  logic [3:0]  digit_en,
    input  logic        lz_blank,
    output logic [3:0]  digit_out,
    output logic [3:0]  seg_an,
    output logic [1:0]  digit_idx,
    output logic        frame_start
);

    logic tick;
    logic in_guard;

    idx_t        idx_q, idx_d;
    logic [15:0] pending_q, pending_d;
    logic [15:0] shadow_q, shadow_d;
    logic [3:0]  dout_q, dout_d;
    logic [3:0]  an_q, an_d;
    logic        fs_q, fs_d;

    logic [NUM_DIGITS-1:0] blank_mask;
    logic                  blanked;

    refresh_tick #(
        .DIGIT_TICKS (DIGIT_TICKS),
        .GUARD_TICKS (GUARD_TICKS)
    ) u_refresh_tick (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .tick_o     (tick),
        .in_guard_o (in_guard)
    );

    // Slot advance and buffer commit; a load on the committing tick bypasses pending.
    always_comb begin
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        pending_d = load ? value_in : pending_q;
        fs_d      = 1'b0;
        if (tick) begin
            idx_d = idx_q + 1'b1;
            if (idx_d == '0) begin
                shadow_d = load ? value_in : pending_q;
                fs_d     = 1'b1;
            end
        end
    end

    // Output decode from the post-edge slot state so digit and anode change together.
    always_comb begin
        blank_mask = ~digit_en | (lz_blank ? lz_mask(shadow_d) : '0);
        blanked    = blank_mask[idx_d];
        dout_d     = blanked ? BLANK_CODE : shadow_d[{idx_d, 2'b00} +: 4];
        an_d       = (in_guard || blanked) ? AN_OFF : ~(4'b0001 << idx_d);
    end

    // State and registered outputs; idx resets to 3 so the first tick opens a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= idx_t'(NUM_DIGITS - 1);
            pending_q <= 16'h0000;
            shadow_q  <= 16'h0000;
            dout_q    <= BLANK_CODE;
            an_q      <= AN_OFF;
            fs_q      <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
            dout_q    <= dout_d;
            an_q      <= an_d;
            fs_q      <= fs_d;
        end
    end

    assign digit_out   = dout_q;
    assign seg_an      = an_q;
    assign digit_idx   = idx_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_disp_scan_mux.sv
// Scoreboard bench for disp_scan_mux with a cycle-count reference model.
module tb_disp_scan_mux;

    localparam int DT = 8;
    localparam int GT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value_in = 16'h0;
    logic        load = 1'b0;
    logic [3:0]  digit_en = 4'hF;
    logic        lz_blank = 1'b0;
    logic [3:0]  digit_out;
    logic [3:0]  seg_an;
    logic [1:0]  digit_idx;
    logic        frame_start;

    always #5 clk = ~clk;

    disp_scan_mux #(
        .DIGIT_TICKS (DT),
        .GUARD_TICKS (GT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .value_in    (value_in),
        .load        (load),
        .digit_en    (digit_en),
        .lz_blank    (lz_blank),
        .digit_out   (digit_out),
        .seg_an      (seg_an),
        .digit_idx   (digit_idx),
        .frame_start (frame_start)
    );

    typedef struct {
        int         n;
        logic [1:0] idx;
        logic       fs;
        logic [3:0] dout;
        logic [3:0] an;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: edges since reset release, pending and displayed values.
    int          n_m = 0;
    logic [15:0] pend_m = 16'h0;
    logic [15:0] shad_m = 16'h0;

    function automatic int idx_at(int n);
        return (3 + n / DT) % 4;
    endfunction

    function automatic logic is_blank(int i, logic [15:0] shad, logic [3:0] en, logic lz);
        return (en[i] == 1'b0) || (lz && i >= 1 && (shad >> (4 * i)) == 16'h0);
    endfunction

    task automatic check(string name, logic [15:0] act, logic [15:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic model_reset();
        n_m    = 0;
        pend_m = 16'h0;
        shad_m = 16'h0;
    endtask

    // Drive one cycle of stimulus, predict the post-edge outputs and queue them.
    task automatic step(logic ld, logic [15:0] val);
        exp_t e;
        int   p;
        int   idx;
        logic commit;
        logic blk;
        load     = ld;
        value_in = val;
        @(posedge clk);
        n_m++;
        p      = n_m % DT;
        idx    = idx_at(n_m);
        commit = (p == 0) && (idx == 0);
        if (commit) shad_m = ld ? val : pend_m;
        if (ld) pend_m = val;
        blk    = is_blank(idx, shad_m, digit_en, lz_blank);
        e.n    = n_m;
        e.idx  = 2'(idx);
        e.fs   = commit;
        e.dout = blk ? 4'hF : 4'((shad_m >> (4 * idx)) & 16'hF);
        e.an   = (p < GT || blk) ? 4'hF : ~(4'b0001 << idx);
        exp_q.push_back(e);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic run(int k);
        repeat (k) step(1'b0, 16'h0);
    endtask

    // Monitor: outputs are registered, so every negedge presents a new observation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("scan n=%0d {idx,fs,digit,an}", e.n),
                      16'({digit_idx, frame_start, digit_out, seg_an}),
                      16'({e.idx, e.fs, e.dout, e.an}));
            end
        end
    end

    initial begin
        // Reset held for 5 cycles.
        repeat (5) @(negedge clk);
        check("reset seg_an", 16'(seg_an), 16'hF);
        check("reset digit_out", 16'(digit_out), 16'hF);
        check("reset frame_start", 16'(frame_start), 16'h0);
        check("reset digit_idx", 16'(digit_idx), 16'h3);
        rst_n = 1'b1;
        model_reset();

        // Plain scan of 1234, loaded before the first tick.
        step(1'b1, 16'h1234);
        run(79);

        // Leading-zero suppression.
        lz_blank = 1'b1;
        step(1'b1, 16'h0070);
        run(40);
        step(1'b1, 16'h0000);
        run(40);
        lz_blank = 1'b0;

        // Mid-frame load during slot 1.
        for (int k = 0; k < 64 && !(idx_at(n_m) == 1 && n_m % DT == 3); k++) step(1'b0, 16'h0);
        step(1'b1, 16'h5678);
        run(48);

        // Load on the committing tick: next edge is the frame boundary.
        for (int k = 0; k < 64 && !(idx_at(n_m) == 3 && n_m % DT == DT - 1); k++) begin
            step(1'b0, 16'h0);
        end
        step(1'b1, 16'h9999);
        run(40);

        // Enable mask, then asynchronous reset in the middle of slot 2.
        digit_en = 4'b0101;
        run(40);
        step(1'b1, 16'h4321);
        for (int k = 0; k < 64 && !(idx_at(n_m) == 2 && n_m % DT == 4); k++) step(1'b0, 16'h0);
        #2 rst_n = 1'b0;
        #1;
        check("async reset seg_an", 16'(seg_an), 16'hF);
        check("async reset digit_out", 16'(digit_out), 16'hF);
        check("async reset digit_idx", 16'(digit_idx), 16'h3);
        check("async reset frame_start", 16'(frame_start), 16'h0);
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        digit_en = 4'hF;
        model_reset();
        run(48);

        // Randomized loads, enables and blanking.
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(15) == 0) digit_en = 4'($urandom);
            if ($urandom_range(31) == 0) lz_blank = ~lz_blank;
            if ($urandom_range(3) == 0) begin
                step($urandom_range(7) == 0, 16'($urandom & 32'h00FF));
            end else begin
                step($urandom_range(7) == 0, 16'($urandom));
            end
        end

        repeat (2) @(negedge clk);
        check("scoreboard drained", 16'(exp_q.size()), 16'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
